// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } dmem_state_e;

    localparam int unsigned LaneW           = 8;
    localparam int unsigned NumLanes        = 4;
    localparam logic [31:0] DefaultBaseAddr = 32'h0000_0000;

    // Below-base addresses wrap to large offsets and therefore miss.
    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                      input int unsigned depth);
        logic [31:0] off;
        logic [32:0] span;
        off  = addr - base;
        span = 33'(depth) << 2;
        return {1'b0, off} < span;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage: one lane-masked write port and one registered read port, no reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [NumLanes-1:0] be_i,
    input  logic                re_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [31:0]         wdata_i,
    output logic [31:0]         rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < int'(NumLanes); i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][i*LaneW +: LaneW] <= wdata_i[i*LaneW +: LaneW];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory bus responder: accepts one request, inserts WAIT_CYCLES wait states,
// then returns a one-cycle ack with byte-masked write storage and range error.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = DefaultBaseAddr,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                sel_i,
    input  logic                we_i,
    input  logic [NumLanes-1:0] byte_en_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         din_i,
    output logic [31:0]         dout_o,
    output logic                ack_o,
    output logic                err_o
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [3:0]  LastCnt = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_e         state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [NumLanes-1:0] be_q;
    logic [31:0]         addr_q, din_q;
    logic                ack_q, err_q, zero_q;

    logic                capture, enter_resp, hit;
    logic                req_we;
    logic [NumLanes-1:0] req_be;
    logic [31:0]         req_addr, req_din, arr_rdata;

    // With zero wait states the request is served on the accepting edge, so the
    // live inputs stand in for the not-yet-captured fields.
    always_comb begin
        if (state_q == StIdle) begin
            req_we   = we_i;
            req_be   = byte_en_i;
            req_addr = addr_i;
            req_din  = din_i;
        end else begin
            req_we   = we_q;
            req_be   = be_q;
            req_addr = addr_q;
            req_din  = din_q;
        end
    end

    assign hit = in_range(req_addr, BASE_ADDR, DEPTH);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sel_i) begin
                    capture = 1'b1;
                    cnt_d   = 4'd0;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!sel_i) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (cnt_q == LastCnt) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                    cnt_d      = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= 32'h0;
            din_q   <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= enter_resp;
            err_q   <= enter_resp & ~hit;
            if (capture) begin
                we_q   <= we_i;
                be_q   <= byte_en_i;
                addr_q <= addr_i;
                din_q  <= din_i;
            end
            // Read data is forced to zero after reset and after an out-of-range read.
            if (enter_resp && !req_we) begin
                zero_q <= ~hit;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (enter_resp & req_we & hit),
        .be_i    (req_be),
        .re_i    (enter_resp & ~req_we & hit),
        .addr_i  (req_addr[AW+1:2]),
        .wdata_i (req_din),
        .rdata_o (arr_rdata)
    );

    assign dout_o = zero_q ? 32'h0 : arr_rdata;
    assign ack_o  = ack_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder over four configurations.
module tb_dmem_responder;

    localparam int          NI    = 4;
    localparam int unsigned DEPTH = 1024;

    function automatic int unsigned cfg_wait(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] cfg_base(input int i);
        return (i == 3) ? 32'h0000_0100 : 32'h0000_0000;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel [NI];
    logic        we [NI];
    logic [3:0]  be [NI];
    logic [31:0] addr [NI];
    logic [31:0] din [NI];
    logic [31:0] dout [NI];
    logic        ack [NI];
    logic        err [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH       (DEPTH),
            .BASE_ADDR   (cfg_base(g)),
            .WAIT_CYCLES (cfg_wait(g))
        ) u_dut (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .sel_i     (sel[g]),
            .we_i      (we[g]),
            .byte_en_i (be[g]),
            .addr_i    (addr[g]),
            .din_i     (din[g]),
            .dout_o    (dout[g]),
            .ack_o     (ack[g]),
            .err_o     (err[g])
        );
    end

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: word contents keyed by (instance, word offset) and last read data.
    bit [31:0] mem_m [longint];
    bit [31:0] dout_m [NI];

    function automatic bit m_hit(input int k, input logic [31:0] a);
        bit [31:0] off;
        off = a - cfg_base(k);
        return off < 32'(DEPTH * 4);
    endfunction

    function automatic longint m_key(input int k, input logic [31:0] a);
        bit [31:0] off;
        off = a - cfg_base(k);
        return (longint'(k) << 32) | longint'(off / 4);
    endfunction

    // Called at a negedge. lead=1 when the previous request kept sel high.
    task automatic txn(input int k, input bit w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input bit hold, input int lead);
        int        n;
        bit        got;
        bit        h;
        longint    key;
        bit [31:0] word;
        sel[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; din[k] = d;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (ack[k] === 1'b1) got = 1'b1;
        end
        check_eq($sformatf("ack_latency[%0d]", k), 32'(n), 32'(cfg_wait(k) + 1 + lead));
        h   = m_hit(k, a);
        key = m_key(k, a);
        if (h && w) begin
            word = mem_m.exists(key) ? mem_m[key] : 32'h0;
            for (int i = 0; i < 4; i++) if (b[i]) word[i*8 +: 8] = d[i*8 +: 8];
            mem_m[key] = word;
        end else if (!w) begin
            dout_m[k] = (h && mem_m.exists(key)) ? mem_m[key] : 32'h0;
        end
        check_eq($sformatf("err[%0d]", k), 32'(err[k]), 32'(!h));
        check_eq($sformatf("dout[%0d]@%h", k, a), dout[k], dout_m[k]);
        if (!hold) begin
            sel[k] = 1'b0;
            @(negedge clk);
            check_eq($sformatf("ack_pulse[%0d]", k), 32'(ack[k]), 32'h0);
        end
    endtask

    initial begin
        bit          prev_hold;
        bit          hold;
        logic [31:0] a;
        for (int k = 0; k < NI; k++) begin
            sel[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0; addr[k] = 32'h0; din[k] = 32'h0;
            dout_m[k] = 32'h0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check_eq($sformatf("rst_ack[%0d]", k), 32'(ack[k]), 32'h0);
            check_eq($sformatf("rst_err[%0d]", k), 32'(err[k]), 32'h0);
            check_eq($sformatf("rst_dout[%0d]", k), dout[k], 32'h0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write/read with one wait state.
        txn(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0);
        txn(0, 0, 4'hF, 32'h10, 32'h0, 0, 0);
        check_eq("basic_read", dout[0], 32'hDEADBEEF);

        // Lane masking and empty mask.
        txn(0, 1, 4'hF, 32'h20, 32'h11223344, 0, 0);
        txn(0, 1, 4'b0101, 32'h20, 32'hAABBCCDD, 0, 0);
        txn(0, 0, 4'hF, 32'h20, 32'h0, 0, 0);
        check_eq("lane_mix", dout[0], 32'h11BB33DD);
        txn(0, 1, 4'b0000, 32'h20, 32'hFFFFFFFF, 0, 0);
        txn(0, 0, 4'hF, 32'h20, 32'h0, 0, 0);
        check_eq("lane_none", dout[0], 32'h11BB33DD);

        // Range edges, including below-base wrap.
        txn(0, 0, 4'hF, 32'h1000, 32'h0, 0, 0);
        txn(0, 1, 4'hF, 32'hFFC, 32'hCAFEF00D, 0, 0);
        txn(0, 0, 4'hF, 32'hFFC, 32'h0, 0, 0);
        txn(3, 0, 4'hF, 32'h0FC, 32'h0, 0, 0);
        txn(3, 1, 4'hF, 32'h100, 32'h01020304, 0, 0);
        txn(3, 0, 4'hF, 32'h100, 32'h0, 0, 0);

        // Abort during wait states.
        txn(1, 1, 4'hF, 32'h40, 32'h00000077, 0, 0);
        txn(1, 0, 4'hF, 32'h40, 32'h0, 0, 0);
        sel[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h40; din[1] = 32'h5;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        sel[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("abort_no_ack", 32'(ack[1]), 32'h0);
        end
        txn(1, 0, 4'hF, 32'h40, 32'h0, 0, 0);

        // Back-to-back with zero wait states.
        txn(2, 1, 4'hF, 32'h0, 32'hA0A0A0A0, 0, 0);
        txn(2, 1, 4'hF, 32'h4, 32'hB1B1B1B1, 0, 0);
        txn(2, 1, 4'hF, 32'h8, 32'hC2C2C2C2, 0, 0);
        txn(2, 0, 4'hF, 32'h0, 32'h0, 1, 0);
        txn(2, 0, 4'hF, 32'h4, 32'h0, 1, 1);
        txn(2, 0, 4'hF, 32'h8, 32'h0, 0, 1);
        txn(2, 1, 4'hF, 32'hC, 32'h13579BDF, 1, 0);
        txn(2, 0, 4'hF, 32'hC, 32'h0, 0, 1);

        // Reset in the middle of a pending write.
        sel[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h40; din[1] = 32'h99;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ack", 32'(ack[1]), 32'h0);
        check_eq("midrst_err", 32'(err[1]), 32'h0);
        check_eq("midrst_dout", dout[1], 32'h0);
        sel[1] = 1'b0;
        for (int k = 0; k < NI; k++) dout_m[k] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(1, 0, 4'hF, 32'h40, 32'h0, 0, 0);
        check_eq("rst_discard", dout[1], 32'h00000077);

        // Randomized traffic over preloaded words plus occasional misses.
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 8; i++) begin
                txn(k, 1, 4'hF, cfg_base(k) + 32'(i * 'h84), $urandom, 0, 0);
            end
            prev_hold = 1'b0;
            for (int t = 0; t < 40; t++) begin
                case ($urandom_range(0, 9))
                    0:       a = cfg_base(k) + 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
                    1:       a = cfg_base(k) - 32'($urandom_range(1, 64) * 4);
                    default: a = cfg_base(k) + 32'($urandom_range(0, 7) * 'h84)
                                 + 32'($urandom_range(0, 3));
                endcase
                hold = (t != 39) && ($urandom_range(0, 1) == 1);
                txn(k, 1'($urandom), 4'($urandom), a, $urandom, hold, int'(prev_hold));
                prev_hold = hold;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
